// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration controller.
package fll_cfg_pkg;

  // Handshake controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } fll_cfg_state_e;

  // FLL register offsets carried on CFGAD
  localparam logic [1:0] REG_CFG1      = 2'd0;
  localparam logic [1:0] REG_CFG2      = 2'd1;
  localparam logic [1:0] REG_INTEG     = 2'd2;
  localparam logic [1:0] REG_STATUS_RO = 2'd3;

  // Target index that selects the local lock status register
  localparam logic [3:0] STATUS_IDX = 4'hF;

  // Default per-phase handshake timeout in controller clocks
  localparam int DEFAULT_TIMEOUT = 1024;

  // One-hot decode of a 4-bit target index
  function automatic logic [15:0] idx_onehot(input logic [3:0] idx);
    idx_onehot = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/fll_cfg_sync.sv
// Multi-stage synchronizer for asynchronous FLL status/acknowledge lines.
module fll_cfg_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_r;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q_o = sync_r[STAGES-1];

endmodule

// File: rtl/fll_cfg_ctrl.sv
// Bridges register_interface accesses onto the FLL CFGREQ/CFGACK
// four-phase configuration handshake, with a local lock status register.
module fll_cfg_ctrl
  import fll_cfg_pkg::*;
#(
  parameter int NUM_FLL        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_valid_i,
  input  logic                  reg_write_i,
  input  logic [7:0]            reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic                  reg_ready_o,
  output logic [31:0]           reg_rdata_o,
  output logic                  reg_error_o,
  output logic [NUM_FLL-1:0]    fll_req_o,
  input  logic [NUM_FLL-1:0]    fll_ack_i,
  output logic [1:0]            fll_add_o,
  output logic [31:0]           fll_data_o,
  output logic                  fll_wrn_o,
  input  logic [NUM_FLL*32-1:0] fll_r_data_i,
  input  logic [NUM_FLL-1:0]    fll_lock_i
);

  // Counter is at least 10 bits so the default 1024-cycle timeout fits
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 10) ? $clog2(TIMEOUT_CYCLES) : 10;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fll_cfg_state_e      state_r, state_next_s;
  logic [3:0]          idx_r, idx_next_s;
  logic                write_r, write_next_s;
  logic                abort_r, abort_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [31:0]         cap_r, cap_next_s;
  logic [NUM_FLL-1:0]  req_r, req_next_s;
  logic [1:0]          add_r, add_next_s;
  logic [31:0]         data_r, data_next_s;
  logic                wrn_r, wrn_next_s;
  logic                ready_r, ready_next_s;
  logic [31:0]         rdata_r, rdata_next_s;
  logic                error_r, error_next_s;

  logic [NUM_FLL-1:0]  ack_sync_s;
  logic [NUM_FLL-1:0]  lock_sync_s;
  logic [15:0]         ack_pad_s;
  logic [511:0]        rdata_pad_s;
  logic                ack_sel_s;
  logic [31:0]         rdata_sel_s;
  logic [3:0]          idx_in_s;
  logic                unused_addr_s;

  fll_cfg_sync #(.WIDTH(NUM_FLL), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (fll_ack_i),
    .q_o    (ack_sync_s)
  );

  fll_cfg_sync #(.WIDTH(NUM_FLL), .STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (fll_lock_i),
    .q_o    (lock_sync_s)
  );

  // Pad per-FLL vectors to the full 16-target space so a 4-bit index
  // selects without width games; unused slots read as zero.
  assign ack_pad_s     = 16'(ack_sync_s);
  assign rdata_pad_s   = 512'(fll_r_data_i);
  assign ack_sel_s     = ack_pad_s[idx_r];
  assign rdata_sel_s   = rdata_pad_s[{idx_r, 5'd0} +: 32];
  assign idx_in_s      = reg_addr_i[7:4];
  assign unused_addr_s = ^reg_addr_i[1:0];

  // Next-state and next-output decode for the handshake FSM
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    write_next_s = write_r;
    abort_next_s = abort_r;
    cnt_next_s   = cnt_r + CNT_W'(1);
    cap_next_s   = cap_r;
    req_next_s   = '0;
    add_next_s   = add_r;
    data_next_s  = data_r;
    wrn_next_s   = wrn_r;
    ready_next_s = 1'b0;
    rdata_next_s = 32'd0;
    error_next_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (reg_valid_i) begin
          idx_next_s   = idx_in_s;
          write_next_s = reg_write_i;
          if (idx_in_s < 4'(NUM_FLL)) begin
            // Shared CFG outputs only change when a new handshake starts
            state_next_s = ST_REQ;
            cnt_next_s   = '0;
            abort_next_s = 1'b0;
            cap_next_s   = 32'd0;
            add_next_s   = reg_addr_i[3:2];
            data_next_s  = reg_wdata_i;
            wrn_next_s   = ~reg_write_i;
            req_next_s   = NUM_FLL'(idx_onehot(idx_in_s));
          end else if (idx_in_s == STATUS_IDX) begin
            state_next_s = ST_RESP;
            ready_next_s = 1'b1;
            rdata_next_s = 32'(lock_sync_s);
          end else begin
            state_next_s = ST_RESP;
            ready_next_s = 1'b1;
            error_next_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      ST_REQ: begin
        req_next_s = NUM_FLL'(idx_onehot(idx_r));
        if (ack_sel_s) begin
          state_next_s = ST_RELEASE;
          cnt_next_s   = '0;
          req_next_s   = '0;
          cap_next_s   = write_r ? 32'd0 : rdata_sel_s;
        end else if (cnt_r == TO_LAST) begin
          state_next_s = ST_RELEASE;
          cnt_next_s   = '0;
          req_next_s   = '0;
          abort_next_s = 1'b1;
        end else begin
          state_next_s = ST_REQ;
        end
      end

      ST_RELEASE: begin
        if (!ack_sel_s) begin
          state_next_s = ST_RESP;
          ready_next_s = 1'b1;
          error_next_s = abort_r;
          rdata_next_s = abort_r ? 32'd0 : cap_r;
        end else if (cnt_r == TO_LAST) begin
          state_next_s = ST_RESP;
          abort_next_s = 1'b1;
          ready_next_s = 1'b1;
          error_next_s = 1'b1;
        end else begin
          state_next_s = ST_RELEASE;
        end
      end

      ST_RESP: begin
        state_next_s = ST_IDLE;
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops CFGREQ immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      write_r <= 1'b0;
      abort_r <= 1'b0;
      cnt_r   <= '0;
      cap_r   <= 32'd0;
      req_r   <= '0;
      add_r   <= 2'd0;
      data_r  <= 32'd0;
      wrn_r   <= 1'b1;
      ready_r <= 1'b0;
      rdata_r <= 32'd0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      write_r <= write_next_s;
      abort_r <= abort_next_s;
      cnt_r   <= cnt_next_s;
      cap_r   <= cap_next_s;
      req_r   <= req_next_s;
      add_r   <= add_next_s;
      data_r  <= data_next_s;
      wrn_r   <= wrn_next_s;
      ready_r <= ready_next_s;
      rdata_r <= rdata_next_s;
      error_r <= error_next_s;
    end
  end

  assign reg_ready_o = ready_r;
  assign reg_rdata_o = rdata_r;
  assign reg_error_o = error_r;
  assign fll_req_o   = req_r;
  assign fll_add_o   = add_r;
  assign fll_data_o  = data_r;
  assign fll_wrn_o   = wrn_r;

endmodule
